// File: rtl/ir_src_pkg.sv
// rtl/ir_src_pkg.sv - shared IR-source select encodings and sequencer state encoding
package ir_src_pkg;

    // EX/MEM instruction mux select values; 2'b11 is never driven
    localparam logic [1:0] IRSRC_MEM = 2'b00;
    localparam logic [1:0] IRSRC_NOP = 2'b01;
    localparam logic [1:0] IRSRC_BNE = 2'b10;

    // Sequencer state encoding, also decoded by the hazard unit
    localparam logic [2:0] STATE_RUN      = 3'd0;
    localparam logic [2:0] STATE_STALL    = 3'd1;
    localparam logic [2:0] STATE_WAIT     = 3'd2;
    localparam logic [2:0] STATE_REDIRECT = 3'd3;
    localparam logic [2:0] STATE_FLUSH    = 3'd4;

    typedef enum logic [2:0] {
        ST_RUN      = STATE_RUN,
        ST_STALL    = STATE_STALL,
        ST_WAIT     = STATE_WAIT,
        ST_REDIRECT = STATE_REDIRECT,
        ST_FLUSH    = STATE_FLUSH
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Clear wins over increment; the count sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ir_src_sequencer.sv
// rtl/ir_src_sequencer.sv - IR-source select, PC and IF/ID write-enable sequencer
module ir_src_sequencer
    import ir_src_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_MAX    = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             clr_stats,
    output logic [1:0]       irsrc,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             branch_ack,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] nop_count
);

    localparam logic [7:0] STALL_LIM  = 8'(STALL_MAX);
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

    seq_state_t state;
    seq_state_t state_nxt;
    logic [7:0] stall_cnt;
    logic [3:0] flush_cnt;
    logic       stall_expired;
    logic       timeout_hit;
    logic       nop_inc;

    assign stall_expired = (stall_cnt == STALL_LIM);
    // Watchdog fires only when the stall would otherwise have continued
    assign timeout_hit   = (state == ST_STALL) && !branch_taken && load_use_hazard && stall_expired;

    // Next-state selection; branch requests outrank bubbles everywhere they are honoured
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN: begin
                if (branch_taken)         state_nxt = ST_REDIRECT;
                else if (load_use_hazard) state_nxt = ST_STALL;
                else if (!imem_ready)     state_nxt = ST_WAIT;
                else                      state_nxt = ST_RUN;
            end
            ST_STALL: begin
                if (branch_taken)          state_nxt = ST_REDIRECT;
                else if (!load_use_hazard) state_nxt = ST_RUN;
                else if (stall_expired)    state_nxt = ST_RUN;
                else                       state_nxt = ST_STALL;
            end
            ST_WAIT: begin
                if (imem_ready && branch_taken) state_nxt = ST_REDIRECT;
                else if (imem_ready)            state_nxt = ST_RUN;
                else                            state_nxt = ST_WAIT;
            end
            ST_REDIRECT: begin
                state_nxt = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
            end
            ST_FLUSH: begin
                state_nxt = (flush_cnt == 4'd0) ? ST_RUN : ST_FLUSH;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // State, inline counters and registered Moore outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            stall_cnt     <= 8'd0;
            flush_cnt     <= 4'd0;
            irsrc         <= IRSRC_NOP;
            pc_write      <= 1'b0;
            ifid_write    <= 1'b0;
            branch_ack    <= 1'b0;
            stall_timeout <= 1'b0;
        end else begin
            state <= state_nxt;

            if ((state_nxt == ST_STALL) && (state != ST_STALL)) begin
                stall_cnt <= 8'd1;
            end else if ((state == ST_STALL) && (state_nxt == ST_STALL)) begin
                stall_cnt <= stall_cnt + 8'd1;
            end

            if (state == ST_REDIRECT) begin
                flush_cnt <= FLUSH_LOAD;
            end else if ((state == ST_FLUSH) && (flush_cnt != 4'd0)) begin
                flush_cnt <= flush_cnt - 4'd1;
            end

            if (clr_stats) begin
                stall_timeout <= 1'b0;
            end else if (timeout_hit) begin
                stall_timeout <= 1'b1;
            end

            irsrc      <= IRSRC_NOP;
            pc_write   <= 1'b0;
            ifid_write <= 1'b0;
            branch_ack <= 1'b0;
            unique case (state_nxt)
                ST_RUN: begin
                    irsrc      <= IRSRC_MEM;
                    pc_write   <= 1'b1;
                    ifid_write <= 1'b1;
                end
                ST_REDIRECT: begin
                    irsrc      <= IRSRC_BNE;
                    pc_write   <= 1'b1;
                    ifid_write <= 1'b1;
                    branch_ack <= 1'b1;
                end
                ST_FLUSH: begin
                    pc_write   <= 1'b1;
                    ifid_write <= 1'b1;
                end
                default: begin
                    irsrc <= IRSRC_NOP;
                end
            endcase
        end
    end

    // The reset-release cycle shows NOP while the FSM is already in RUN; it is not a real bubble
    assign nop_inc = (irsrc == IRSRC_NOP) && (state != ST_RUN);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_nop_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (nop_inc),
        .clr   (clr_stats),
        .count (nop_count)
    );

endmodule

// File: tb/tb_ir_src_sequencer.sv
// tb/tb_ir_src_sequencer.sv - directed self-checking bench for ir_src_sequencer
module tb_ir_src_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_use_hazard;
    logic        branch_taken;
    logic        imem_ready;
    logic        clr_stats;
    logic [1:0]  irsrc;
    logic        pc_write;
    logic        ifid_write;
    logic        branch_ack;
    logic        stall_timeout;
    logic [15:0] nop_count;

    logic [1:0]  s_irsrc;
    logic        s_pc_write;
    logic        s_ifid_write;
    logic        s_branch_ack;
    logic        s_stall_timeout;
    logic [3:0]  s_nop_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ir_src_sequencer #(
        .FLUSH_CYCLES (2),
        .STALL_MAX    (4),
        .CNT_W        (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_use_hazard (load_use_hazard),
        .branch_taken    (branch_taken),
        .imem_ready      (imem_ready),
        .clr_stats       (clr_stats),
        .irsrc           (irsrc),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .branch_ack      (branch_ack),
        .stall_timeout   (stall_timeout),
        .nop_count       (nop_count)
    );

    ir_src_sequencer #(
        .FLUSH_CYCLES (2),
        .STALL_MAX    (4),
        .CNT_W        (4)
    ) dut_sat (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_use_hazard (load_use_hazard),
        .branch_taken    (branch_taken),
        .imem_ready      (imem_ready),
        .clr_stats       (clr_stats),
        .irsrc           (s_irsrc),
        .pc_write        (s_pc_write),
        .ifid_write      (s_ifid_write),
        .branch_ack      (s_branch_ack),
        .stall_timeout   (s_stall_timeout),
        .nop_count       (s_nop_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] e_irsrc, input logic e_pcw,
                              input logic e_ifid, input logic e_ack);
        check({tag, ".irsrc"}, 32'(irsrc), 32'(e_irsrc));
        check({tag, ".pc_write"}, 32'(pc_write), 32'(e_pcw));
        check({tag, ".ifid_write"}, 32'(ifid_write), 32'(e_ifid));
        check({tag, ".branch_ack"}, 32'(branch_ack), 32'(e_ack));
    endtask

    logic [9:0] nop_pattern;

    initial begin
        rst_n           = 1'b0;
        load_use_hazard = 1'b0;
        branch_taken    = 1'b0;
        imem_ready      = 1'b1;
        clr_stats       = 1'b0;

        // Reset held for three edges
        repeat (3) step();
        check_outs("reset", 2'b01, 1'b0, 1'b0, 1'b0);
        check("reset.stall_timeout", 32'(stall_timeout), 32'd0);
        check("reset.nop_count", 32'(nop_count), 32'd0);

        // Release and idle
        rst_n = 1'b1;
        step();
        check_outs("idle1", 2'b00, 1'b1, 1'b1, 1'b0);
        step();
        step();
        check_outs("idle3", 2'b00, 1'b1, 1'b1, 1'b0);
        check("idle.nop_count", 32'(nop_count), 32'd0);

        // Taken branch: 10, 01, 01, 00
        branch_taken = 1'b1;
        step();
        check_outs("br.redirect", 2'b10, 1'b1, 1'b1, 1'b1);
        branch_taken = 1'b0;
        step();
        check_outs("br.flush1", 2'b01, 1'b1, 1'b1, 1'b0);
        step();
        check_outs("br.flush2", 2'b01, 1'b1, 1'b1, 1'b0);
        step();
        check_outs("br.run", 2'b00, 1'b1, 1'b1, 1'b0);
        check("br.nop_count", 32'(nop_count), 32'd2);

        // Load-use for two cycles
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check("clr.nop_count", 32'(nop_count), 32'd0);
        load_use_hazard = 1'b1;
        step();
        check_outs("lu.stall1", 2'b01, 1'b0, 1'b0, 1'b0);
        step();
        check_outs("lu.stall2", 2'b01, 1'b0, 1'b0, 1'b0);
        load_use_hazard = 1'b0;
        step();
        check_outs("lu.run", 2'b00, 1'b1, 1'b1, 1'b0);
        check("lu.stall_timeout", 32'(stall_timeout), 32'd0);
        check("lu.nop_count", 32'(nop_count), 32'd2);

        // Watchdog: hazard held ten edges, streaks of four STALL cycles
        load_use_hazard = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            nop_pattern[i] = (irsrc == 2'b01);
        end
        load_use_hazard = 1'b0;
        check("wd.pattern", 32'(nop_pattern), 32'(10'b0111101111));
        check("wd.stall_timeout", 32'(stall_timeout), 32'd1);
        step();
        step();
        check("wd.sticky", 32'(stall_timeout), 32'd1);
        check("wd.nop_count", 32'(nop_count), 32'd10);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check("wd.cleared", 32'(stall_timeout), 32'd0);
        check("wd.nop_cleared", 32'(nop_count), 32'd0);

        // Contention: branch beats load-use
        branch_taken    = 1'b1;
        load_use_hazard = 1'b1;
        step();
        check_outs("cont.redirect", 2'b10, 1'b1, 1'b1, 1'b1);
        branch_taken    = 1'b0;
        load_use_hazard = 1'b0;
        step();
        step();
        step();
        check_outs("cont.run", 2'b00, 1'b1, 1'b1, 1'b0);

        // WAIT with a pending branch, redirect only once memory is ready
        imem_ready = 1'b0;
        step();
        check_outs("wait1", 2'b01, 1'b0, 1'b0, 1'b0);
        branch_taken = 1'b1;
        step();
        check_outs("wait2", 2'b01, 1'b0, 1'b0, 1'b0);
        step();
        check_outs("wait3", 2'b01, 1'b0, 1'b0, 1'b0);
        imem_ready = 1'b1;
        step();
        check_outs("wait.redirect", 2'b10, 1'b1, 1'b1, 1'b1);
        branch_taken = 1'b0;
        step();
        step();
        step();
        check_outs("wait.run", 2'b00, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a flush
        branch_taken = 1'b1;
        step();
        branch_taken = 1'b0;
        step();
        check_outs("ar.flush", 2'b01, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("ar.async", 2'b01, 1'b0, 1'b0, 1'b0);
        check("ar.nop_count", 32'(nop_count), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_outs("ar.run", 2'b00, 1'b1, 1'b1, 1'b0);
        check("ar.nop_after", 32'(nop_count), 32'd0);

        // Twenty NOP cycles: 16-bit counter reaches 20, 4-bit counter pins at 15
        imem_ready = 1'b0;
        repeat (20) step();
        imem_ready = 1'b1;
        step();
        check("sat.irsrc", 32'(irsrc), 32'd0);
        check("sat.nop16", 32'(nop_count), 32'd20);
        check("sat.nop4", 32'(s_nop_count), 32'd15);
        step();
        check("sat.nop4_hold", 32'(s_nop_count), 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
